// File: rtl/dsg_mix.sv
// Multi-channel mixer feeding a 1-bit delta-sigma DAC pin: time-multiplexed sum, saturation, modulator.
// Define DSG_MIX_ORDER2_EN to replace the first-order modulator with a second-order one.
module dsg_mix #(
    parameter int CH = 4,
    parameter int W  = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [CH*W-1:0] in,
    input  logic [CH*3-1:0] vol,
    input  logic [CH-1:0]   mute,
    output logic            out,
    output logic            strobe,
    output logic            clip
);

    localparam int SW = W + $clog2(CH);
    localparam int PW = $clog2(CH + 1);
    localparam logic [PW-1:0] LAST = PW'(CH);

    function automatic logic over_range(input logic [SW-1:0] s);
        return |s[SW-1:W];
    endfunction

    function automatic logic [W-1:0] sat_mix(input logic [SW-1:0] s);
        return over_range(s) ? {W{1'b1}} : s[W-1:0];
    endfunction

    logic [PW-1:0] phase_p0;
    logic [SW-1:0] sum_p0;
    logic [W-1:0]  mix_p1;
    logic          vld_p1;
    logic [W-1:0]  term;

    // Only the channel addressed this cycle is looked at; the load phase contributes nothing.
    always_comb begin
        term = '0;
        for (int k = 0; k < CH; k++) begin
            if (phase_p0 == PW'(k) && !mute[k])
                term = in[k*W +: W] >> vol[k*3 +: 3];
        end
    end

    // Stage p0 -> p1: accumulate one channel per clock, load the saturated mix on the last phase
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_p0 <= '0;
            sum_p0   <= '0;
            mix_p1   <= '0;
            vld_p1   <= 1'b0;
            clip     <= 1'b0;
        end else if (phase_p0 == LAST) begin
            mix_p1   <= sat_mix(sum_p0);
            clip     <= clip | over_range(sum_p0);
            sum_p0   <= '0;
            phase_p0 <= '0;
            vld_p1   <= 1'b1;
        end else begin
            sum_p0   <= sum_p0 + SW'(term);
            phase_p0 <= phase_p0 + 1'b1;
            vld_p1   <= 1'b0;
        end
    end

    assign strobe = vld_p1;

`ifdef DSG_MIX_ORDER2_EN
    // Stage p1 -> p2: second-order modulator; four guard bits keep both integrators from wrapping
    logic signed [W+3:0] a1_p2, a2_p2;
    logic signed [W+3:0] fb, mix_s, a1_nx, a2_nx;

    always_comb begin
        mix_s = $signed({4'b0000, mix_p1});
        fb    = out ? $signed({4'b0000, {W{1'b1}}}) : '0;
        a1_nx = a1_p2 + mix_s - fb;
        a2_nx = a2_p2 + a1_nx - fb;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a1_p2 <= '0;
            a2_p2 <= '0;
            out   <= 1'b0;
        end else begin
            a1_p2 <= a1_nx;
            a2_p2 <= a2_nx;
            out   <= ~a2_nx[W+3];
        end
    end
`else
    // Stage p1 -> p2: first-order modulator; the carry out of the accumulator is the bitstream
    logic [W:0] acc_p2;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_p2 <= '0;
            out    <= 1'b0;
        end else begin
            acc_p2 <= {1'b0, acc_p2[W-1:0]} + {1'b0, mix_p1};
            out    <= acc_p2[W];
        end
    end
`endif

endmodule

// File: tb/tb_dsg_mix.sv
// Scoreboard bench for dsg_mix (CH=4, W=15, first-order build): strobe timing, ones density, clip, reset.
module tb_dsg_mix;

    localparam int CH  = 4;
    localparam int W   = 15;
    localparam int WIN = 4096;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [CH*W-1:0] in_s;
    logic [CH*3-1:0] vol_s;
    logic [CH-1:0]   mute_s;
    logic            out_s, strobe_s, clip_s;

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    typedef struct {
        int   tag;
        int   lat;
        int   ones;
        int   strobes;
        logic clip;
    } exp_t;

    exp_t exp_q[$];

    dsg_mix #(.CH(CH), .W(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .in     (in_s),
        .vol    (vol_s),
        .mute   (mute_s),
        .out    (out_s),
        .strobe (strobe_s),
        .clip   (clip_s)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        in_s   = '0;
        vol_s  = '0;
        mute_s = '0;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v, input logic [2:0] a, input logic m);
        in_s[k*W +: W]  = v;
        vol_s[k*3 +: 3] = a;
        mute_s[k]       = m;
    endtask

    task automatic reset_hold();
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    // Expected window: ones = floor(WIN*mix/2^15) since acc starts from 0 after reset;
    // strobes visible in the window = floor((WIN+1)/5) = 819.
    task automatic release_expect(input int tag, input int ones, input logic clp);
        int target;
        bit ok;
        target = done_cnt + 1;
        reset  = 1'b0;
        exp_q.push_back('{tag, 5, ones, 819, clp});
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            if (done_cnt >= target) begin
                ok = 1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL w%0d_timeout: monitor did not complete, expected completion within 6000 cycles", tag);
        end
    endtask

    // Monitor: pops one expectation per measurement and checks it against the observed stream
    initial begin
        exp_t e;
        int   lat, ones, strb;
        forever begin
            wait (exp_q.size() != 0);
            e   = exp_q.pop_front();
            lat = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clock);
                if (strobe_s) begin
                    lat = i;
                    break;
                end
            end
            check($sformatf("w%0d_first_strobe_cycle", e.tag), lat, e.lat);
            @(negedge clock);
            ones = 0;
            strb = 0;
            repeat (WIN) begin
                @(negedge clock);
                ones += int'(out_s);
                strb += int'(strobe_s);
            end
            check($sformatf("w%0d_ones", e.tag), ones, e.ones);
            check($sformatf("w%0d_strobes", e.tag), strb, e.strobes);
            check($sformatf("w%0d_clip", e.tag), int'(clip_s), int'(e.clip));
            done_cnt++;
        end
    end

    // Stimulus
    initial begin
        bit found;
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_out", int'(out_s), 0);
        check("rst_strobe", int'(strobe_s), 0);
        check("rst_clip", int'(clip_s), 0);

        // all channels zero: silence, regular strobes, no clip
        release_expect(0, 0, 1'b0);

        // half scale on ch0
        reset_hold();
        clear_inputs();
        set_ch(0, 15'h4000, 3'd0, 1'b0);
        release_expect(1, 2048, 1'b0);

        // two full-scale channels saturate the sum
        reset_hold();
        clear_inputs();
        set_ch(0, 15'h7FFF, 3'd0, 1'b0);
        set_ch(1, 15'h7FFF, 3'd0, 1'b0);
        release_expect(2, 4095, 1'b1);

        // reset mid-frame at phase 2 while clip is set
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (strobe_s) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL t5_strobe_wait: no strobe seen, expected one within 20 cycles");
        end
        repeat (2) @(negedge clock);
        check("t5_clip_before", int'(clip_s), 1);
        reset = 1'b1;
        clear_inputs();
        set_ch(0, 15'h0100, 3'd0, 1'b0);
        @(negedge clock);
        check("t5_clip_after", int'(clip_s), 0);
        check("t5_out_after", int'(out_s), 0);
        check("t5_strobe_after", int'(strobe_s), 0);
        release_expect(3, 32, 1'b0);

        // attenuation on ch0, mute on ch2
        reset_hold();
        clear_inputs();
        set_ch(0, 15'h7FFF, 3'd3, 1'b0);
        set_ch(2, 15'h1000, 3'd0, 1'b1);
        release_expect(4, 511, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
